// File: rtl/ber_align_checker.sv
// BER checker: sweeps reference-to-receive delays, locks on the best candidate, then counts bits/errors.
// Optional macro BER_RELOCK_EN adds a windowed error monitor that restarts the sweep when errors grow.
module ber_align_checker #(
  parameter int NB_CHAN    = 2,
  parameter int MAX_DELAY  = 511,
  parameter int ALIGN_LEN  = 1024,
  parameter int NB_COUNT   = 64,
  parameter int RELOCK_THR = 64
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic                           i_enable,
  input  logic                           i_valid,
  input  logic [NB_CHAN-1:0]             i_ref_bit,
  input  logic [NB_CHAN-1:0]             i_rx_bit,
  input  logic                           i_clear,
  output logic                           o_aligned,
  output logic [$clog2(MAX_DELAY+1)-1:0] o_lock_delay,
  output logic [NB_COUNT-1:0]            o_bit_count,
  output logic [NB_CHAN*NB_COUNT-1:0]    o_err_count
);
  localparam int DW = $clog2(MAX_DELAY+1);
  localparam int WW = $clog2(ALIGN_LEN);
  localparam int CW = $clog2(NB_CHAN+1);
  localparam int SW = $clog2(ALIGN_LEN*NB_CHAN+1);

  typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, COUNT = 2'd2} state_t;

  function automatic logic [CW-1:0] popcnt(input logic [NB_CHAN-1:0] v);
    logic [CW-1:0] n;
    n = {CW{1'b0}};
    for (int i = 0; i < NB_CHAN; i++) n = n + CW'(v[i]);
    return n;
  endfunction

  function automatic logic [NB_COUNT-1:0] sat_inc(input logic [NB_COUNT-1:0] a, input logic b);
    return (&a) ? a : a + NB_COUNT'(b);
  endfunction

  state_t               state_r;
  logic [MAX_DELAY-1:0] line_r [NB_CHAN];
  logic [DW-1:0]        cand_r;
  logic [WW-1:0]        win_cnt_r;
  logic [SW-1:0]        win_err_r;
  logic [SW-1:0]        best_err_r;
  logic [DW-1:0]        best_dly_r;

  logic [MAX_DELAY:0]   taps_s [NB_CHAN];
  logic [NB_CHAN-1:0]   cand_bits_s;
  logic [NB_CHAN-1:0]   lock_bits_s;
  logic [SW-1:0]        win_sum_s;
  logic                 win_last_s;
  logic                 better_s;
`ifdef BER_RELOCK_EN
  logic [WW-1:0]        mon_cnt_r;
  logic [SW-1:0]        mon_err_r;
  logic [SW-1:0]        mon_sum_s;
  logic                 mon_last_s;
`endif

  // Tap selection and candidate / lock error evaluation for the current sample
  always_comb begin
    cand_bits_s = {NB_CHAN{1'b0}};
    lock_bits_s = {NB_CHAN{1'b0}};
    for (int c = 0; c < NB_CHAN; c++) begin
      taps_s[c]      = {line_r[c], i_ref_bit[c]};
      cand_bits_s[c] = i_rx_bit[c] ^ taps_s[c][cand_r];
      lock_bits_s[c] = i_rx_bit[c] ^ taps_s[c][o_lock_delay];
    end
    win_sum_s  = win_err_r + SW'(popcnt(cand_bits_s));
    win_last_s = (win_cnt_r == WW'(ALIGN_LEN-1));
    // Candidate 0 always seeds the minimum; afterwards only a strictly smaller sum wins
    better_s   = (cand_r == {DW{1'b0}}) || (win_sum_s < best_err_r);
`ifdef BER_RELOCK_EN
    mon_sum_s  = mon_err_r + SW'(popcnt(lock_bits_s));
    mon_last_s = (mon_cnt_r == WW'(ALIGN_LEN-1));
`endif
  end

  // Reference delay line, advanced only by valid samples in every state
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      for (int c = 0; c < NB_CHAN; c++) line_r[c] <= {MAX_DELAY{1'b0}};
    end else if (i_valid) begin
      for (int c = 0; c < NB_CHAN; c++) line_r[c] <= taps_s[c][MAX_DELAY-1:0];
    end
  end

  // Control FSM with search bookkeeping and the result counters
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_r      <= IDLE;
      o_aligned    <= 1'b0;
      o_lock_delay <= {DW{1'b0}};
      o_bit_count  <= {NB_COUNT{1'b0}};
      o_err_count  <= {(NB_CHAN*NB_COUNT){1'b0}};
      cand_r       <= {DW{1'b0}};
      win_cnt_r    <= {WW{1'b0}};
      win_err_r    <= {SW{1'b0}};
      best_err_r   <= {SW{1'b0}};
      best_dly_r   <= {DW{1'b0}};
`ifdef BER_RELOCK_EN
      mon_cnt_r    <= {WW{1'b0}};
      mon_err_r    <= {SW{1'b0}};
`endif
    end else if (!i_enable) begin
      state_r   <= IDLE;
      o_aligned <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_r   <= SEARCH;
          cand_r    <= {DW{1'b0}};
          win_cnt_r <= {WW{1'b0}};
          win_err_r <= {SW{1'b0}};
        end
        SEARCH: begin
          if (i_valid) begin
            if (win_last_s) begin
              win_cnt_r <= {WW{1'b0}};
              win_err_r <= {SW{1'b0}};
              if (better_s) begin
                best_err_r <= win_sum_s;
                best_dly_r <= cand_r;
              end
              if (cand_r == DW'(MAX_DELAY)) begin
                state_r      <= COUNT;
                o_aligned    <= 1'b1;
                o_lock_delay <= better_s ? cand_r : best_dly_r;
                o_bit_count  <= {NB_COUNT{1'b0}};
                o_err_count  <= {(NB_CHAN*NB_COUNT){1'b0}};
`ifdef BER_RELOCK_EN
                mon_cnt_r    <= {WW{1'b0}};
                mon_err_r    <= {SW{1'b0}};
`endif
              end else begin
                cand_r <= cand_r + DW'(1);
              end
            end else begin
              win_cnt_r <= win_cnt_r + WW'(1);
              win_err_r <= win_sum_s;
            end
          end
        end
        COUNT: begin
          if (i_clear) begin
            o_bit_count <= {NB_COUNT{1'b0}};
            o_err_count <= {(NB_CHAN*NB_COUNT){1'b0}};
          end else if (i_valid) begin
            o_bit_count <= sat_inc(o_bit_count, 1'b1);
            for (int c = 0; c < NB_CHAN; c++)
              o_err_count[c*NB_COUNT +: NB_COUNT] <=
                sat_inc(o_err_count[c*NB_COUNT +: NB_COUNT], lock_bits_s[c]);
          end
`ifdef BER_RELOCK_EN
          // Window monitor runs on every valid sample, independent of clears
          if (i_valid) begin
            if (mon_last_s) begin
              mon_cnt_r <= {WW{1'b0}};
              mon_err_r <= {SW{1'b0}};
              if (mon_sum_s > SW'(RELOCK_THR)) begin
                state_r   <= SEARCH;
                o_aligned <= 1'b0;
                cand_r    <= {DW{1'b0}};
                win_cnt_r <= {WW{1'b0}};
                win_err_r <= {SW{1'b0}};
              end
            end else begin
              mon_cnt_r <= mon_cnt_r + WW'(1);
              mon_err_r <= mon_sum_s;
            end
          end
`endif
        end
        default: begin
          state_r   <= IDLE;
          o_aligned <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ber_align_checker.sv
// Bench for ber_align_checker: table of lock scenarios, hand-written corner sequences and random
// traffic, all checked every cycle against an array-based model of the sweep and counters.
module tb_ber_align_checker;
  localparam int NB_CHAN = 2, MAX_DELAY = 15, ALIGN_LEN = 32, NB_COUNT = 16, RELOCK_THR = 8;
  localparam int SWEEP = ALIGN_LEN * (MAX_DELAY + 1);

  logic        clk = 1'b0;
  logic        rst_n, en, valid, clr;
  logic [1:0]  ref_b, rx_b;
  logic        aligned, s_aligned;
  logic [3:0]  lock_dly, s_lock_dly;
  logic [15:0] bit_cnt;
  logic [31:0] err_cnt;
  logic [3:0]  s_bit_cnt;
  logic [7:0]  s_err_cnt;

  always #5 clk = ~clk;

  ber_align_checker #(.NB_CHAN(NB_CHAN), .MAX_DELAY(MAX_DELAY), .ALIGN_LEN(ALIGN_LEN),
                      .NB_COUNT(NB_COUNT), .RELOCK_THR(RELOCK_THR)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_enable(en), .i_valid(valid), .i_ref_bit(ref_b),
    .i_rx_bit(rx_b), .i_clear(clr), .o_aligned(aligned), .o_lock_delay(lock_dly),
    .o_bit_count(bit_cnt), .o_err_count(err_cnt));

  // Narrow-counter copy on the same stimulus, to reach saturation quickly
  ber_align_checker #(.NB_CHAN(NB_CHAN), .MAX_DELAY(MAX_DELAY), .ALIGN_LEN(ALIGN_LEN),
                      .NB_COUNT(4), .RELOCK_THR(RELOCK_THR)) dut_s (
    .i_clock(clk), .i_reset(rst_n), .i_enable(en), .i_valid(valid), .i_ref_bit(ref_b),
    .i_rx_bit(rx_b), .i_clear(clr), .o_aligned(s_aligned), .o_lock_delay(s_lock_dly),
    .o_bit_count(s_bit_cnt), .o_err_count(s_err_cnt));

  int tests = 0, fails = 0;
  int rx_delay = 5;
  bit zero_ref = 1'b0;
  logic [8:0] lfsr = 9'h1A5;

  int m_phase, m_n, m_lock, m_bits, m_e0, m_e1, m_mon_n, m_mon_sum;
  int m_cerr [MAX_DELAY+1];
  logic [1:0] ref_q [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int popc(input logic [1:0] v);
    return int'(v[0]) + int'(v[1]);
  endfunction

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  // Reference bit d valid samples before the current one
  function automatic logic [1:0] tap(input int d, input logic [1:0] cur);
    if (d == 0) return cur;
    if (ref_q.size() >= d) return ref_q[ref_q.size() - d];
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_n = 0; m_lock = 0; m_bits = 0; m_e0 = 0; m_e1 = 0;
    m_mon_n = 0; m_mon_sum = 0;
    foreach (m_cerr[i]) m_cerr[i] = 0;
    ref_q.delete();
  endtask

  task automatic model_edge(input bit v, input bit c, input logic [1:0] r, input logic [1:0] x);
    logic [1:0] e;
    int best;
    if (!en) m_phase = 0;
    else if (m_phase == 0) begin
      m_phase = 1; m_n = 0;
      foreach (m_cerr[i]) m_cerr[i] = 0;
    end else if (m_phase == 1) begin
      if (v) begin
        e = x ^ tap(m_n / ALIGN_LEN, r);
        m_cerr[m_n / ALIGN_LEN] += popc(e);
        m_n++;
        if (m_n == SWEEP) begin
          best = 0;
          for (int d = 1; d <= MAX_DELAY; d++) if (m_cerr[d] < m_cerr[best]) best = d;
          m_lock = best; m_phase = 2; m_bits = 0; m_e0 = 0; m_e1 = 0;
          m_mon_n = 0; m_mon_sum = 0;
        end
      end
    end else begin
      e = x ^ tap(m_lock, r);
      if (c) begin
        m_bits = 0; m_e0 = 0; m_e1 = 0;
      end else if (v) begin
        m_bits++; m_e0 += int'(e[0]); m_e1 += int'(e[1]);
      end
`ifdef BER_RELOCK_EN
      if (v) begin
        m_mon_sum += popc(e);
        m_mon_n++;
        if (m_mon_n == ALIGN_LEN) begin
          if (m_mon_sum > RELOCK_THR) begin
            m_phase = 1; m_n = 0;
            foreach (m_cerr[i]) m_cerr[i] = 0;
          end
          m_mon_n = 0; m_mon_sum = 0;
        end
      end
`endif
    end
    if (v) begin
      ref_q.push_back(r);
      if (ref_q.size() > 32) void'(ref_q.pop_front());
    end
  endtask

  task automatic check_all();
    chk("aligned", aligned, m_phase == 2);
    chk("lock_delay", lock_dly, m_lock);
    chk("bit_count", bit_cnt, sat(m_bits, 65535));
    chk("err_ch0", err_cnt[15:0], sat(m_e0, 65535));
    chk("err_ch1", err_cnt[31:16], sat(m_e1, 65535));
    chk("sat_bit_count", s_bit_cnt, sat(m_bits, 15));
    chk("sat_err_ch0", s_err_cnt[3:0], sat(m_e0, 15));
    chk("sat_err_ch1", s_err_cnt[7:4], sat(m_e1, 15));
  endtask

  task automatic step(input bit v, input bit c, input logic [1:0] fl);
    logic [1:0] r, x;
    if (v) begin
      if (zero_ref) r = 2'b00;
      else begin
        lfsr = {lfsr[7:0], lfsr[8] ^ lfsr[4]};
        r = {lfsr[3], lfsr[0]};
      end
      x = tap(rx_delay, r) ^ fl;
    end else begin
      r = 2'($urandom);
      x = 2'($urandom);
    end
    valid = v; clr = c; ref_b = r; rx_b = x;
    @(posedge clk);
    model_edge(v, c, r, x);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    chk("rst_aligned", aligned, 1'b0);
    chk("rst_lock", lock_dly, 4'd0);
    chk("rst_bits", bit_cnt, 16'd0);
    chk("rst_errs", err_cnt, 32'd0);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_lock(input int budget, input bit rnd, output int steps);
    bit rv;
    steps = 0;
    while (aligned !== 1'b1 && steps < budget) begin
      rv = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      step(rv, 1'b0, 2'b00);
      steps++;
    end
    chk("lock_in_budget", steps < budget, 1'b1);
  endtask

  typedef struct {
    int dly; bit zr; int f0; int f1; int n; int exp_lock;
  } vec_t;
  vec_t tbl [5];

  initial begin
    int steps;
    bit b0, b1, bc;
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int steps;
    bit b0, b1, bc, bv;
    tbl[0] = '{dly: 5,  zr: 1'b0, f0: 0, f1: 0, n: 100, exp_lock: 5};
    tbl[1] = '{dly: 0,  zr: 1'b0, f0: 1, f1: 2, n: 40,  exp_lock: 0};
    tbl[2] = '{dly: 15, zr: 1'b0, f0: 2, f1: 1, n: 40,  exp_lock: 15};
    tbl[3] = '{dly: 3,  zr: 1'b1, f0: 0, f1: 0, n: 20,  exp_lock: 0};
    tbl[4] = '{dly: 5,  zr: 1'b0, f0: 0, f1: 3, n: 60,  exp_lock: 5};
    en = 1'b0; valid = 1'b0; clr = 1'b0; ref_b = 2'b00; rx_b = 2'b00; rst_n = 1'b0;

    foreach (tbl[k]) begin
      do_reset();
      rx_delay = tbl[k].dly; zero_ref = tbl[k].zr; en = 1'b1;
      wait_lock(700, 1'b0, steps);
      chk("tbl_lock_cycles", steps, SWEEP + 1);
      chk("tbl_lock", lock_dly, tbl[k].exp_lock);
      for (int i = 0; i < tbl[k].n; i++)
        step(1'b1, 1'b0, {(i < tbl[k].f1), (i < tbl[k].f0)});
      chk("tbl_bits", bit_cnt, tbl[k].n);
      chk("tbl_err0", err_cnt[15:0], tbl[k].f0);
      chk("tbl_err1", err_cnt[31:16], tbl[k].f1);
    end
    zero_ref = 1'b0;

    // Clear wins over a coincident errored sample
    step(1'b1, 1'b1, 2'b11);
    chk("clr_bits", bit_cnt, 16'd0);
    chk("clr_errs", err_cnt, 32'd0);
    step(1'b1, 1'b0, 2'b00);
    chk("post_clr_bits", bit_cnt, 16'd1);

    for (int i = 0; i < 100; i++) step(i % 2 == 0, 1'b0, 2'b00);
    chk("toggle_bits", bit_cnt, 16'd51);

    // Enable low: idle next cycle, results held, clear ignored
    en = 1'b0;
    step(1'b1, 1'b0, 2'b01);
    chk("idle_aligned", aligned, 1'b0);
    chk("idle_lock", lock_dly, 4'd5);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 2'b11);
    chk("idle_bits_held", bit_cnt, 16'd51);

    // Reset in the middle of candidate 7, then a full fresh sweep
    en = 1'b1;
    for (int i = 0; i < 1 + 7 * ALIGN_LEN + 5; i++) step(1'b1, 1'b0, 2'b00);
    chk("search_lock_held", lock_dly, 4'd5);
    do_reset();
    wait_lock(700, 1'b0, steps);
    chk("rst_relock_cycles", steps, SWEEP + 1);
    chk("rst_relock_lock", lock_dly, 4'd5);

    // Gapped valid during the sweep: lock still defined in valid samples
    en = 1'b0;
    step(1'b1, 1'b0, 2'b00);
    en = 1'b1;
    wait_lock(3000, 1'b1, steps);
    chk("gapped_lock", lock_dly, 4'd5);

    // Random traffic with errors, clears and enable drops
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) en = ~en;
      bv = ($urandom_range(0, 3) != 0);
      b0 = ($urandom_range(0, 7) == 0);
      b1 = ($urandom_range(0, 7) == 0);
      bc = ($urandom_range(0, 49) == 0);
      step(bv, bc, {b1, b0});
    end
    en = 1'b1;

    // Receive delay moves from 5 to 9 while locked
    do_reset();
    rx_delay = 5;
    wait_lock(700, 1'b0, steps);
    chk("pre_shift_lock", lock_dly, 4'd5);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 2'b00);
    rx_delay = 9;
`ifdef BER_RELOCK_EN
    steps = 0;
    while (aligned === 1'b1 && steps < 2 * ALIGN_LEN) begin
      step(1'b1, 1'b0, 2'b00);
      steps++;
    end
    chk("relock_drop", aligned, 1'b0);
    wait_lock(700, 1'b0, steps);
    chk("relock_lock", lock_dly, 4'd9);
`else
    for (int i = 0; i < 70; i++) step(1'b1, 1'b0, 2'b00);
    chk("stay_aligned", aligned, 1'b1);
    chk("err_accum", (err_cnt[15:0] + err_cnt[31:16]) > 17'd0, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
